// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU data-TCM initiator.
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } lsu_funct3_e;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } lsu_state_e;

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic [2:0] f3);
    case (f3)
      LB, LH, LW, LBU, LHU: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  // An access needs a second beat when its last byte lands in the next word.
  function automatic logic crosses(input logic [1:0] off, input logic [2:0] size);
    return ({2'b00, off} + {1'b0, size}) > 4'd4;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Merges the captured bytes of one or two beats and sign/zero-extends the load result.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] bytes_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [63:0] shifted;

  // Byte k sits at lane off+k of the 8-byte {beat1, beat0} window.
  always_comb begin
    shifted = bytes_i >> {off_i, 3'b000};
    case (funct3_i)
      LB:      data_o = {{24{shifted[7]}}, shifted[7:0]};
      LH:      data_o = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     data_o = {24'h000000, shifted[7:0]};
      LHU:     data_o = {16'h0000, shifted[15:0]};
      default: data_o = shifted[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_tcm_master.sv
// Load/store initiator for the data TCM: splits word-crossing accesses and returns one response.
module lsu_tcm_master
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  ready_o,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  lsu_state_e            state_q;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] b0_q;
  logic [DATA_WIDTH-1:0] b1_q;

  logic                    req_err;
  logic [1:0]              off_q;
  logic [2:0]              size_q;
  logic                    cross_q;
  logic [3:0]              be_base;
  logic [7:0]              wide_be;
  logic [2*DATA_WIDTH-1:0] wide_data;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [DATA_WIDTH-1:0]   ext_data;

  assign req_err = !funct3_legal(funct3_i) ||
                   (!ALLOW_MISALIGNED && crosses(addr_i[1:0], size_of(funct3_i)));

  assign off_q     = addr_q[1:0];
  assign size_q    = size_of(f3_q);
  assign cross_q   = crosses(off_q, size_q);
  assign be_base   = (size_q == 3'd1) ? 4'b0001 : (size_q == 3'd2) ? 4'b0011 : 4'b1111;
  // Low half of each window feeds BEAT0, high half BEAT1.
  assign wide_be   = {4'b0000, be_base} << off_q;
  assign wide_data = {{DATA_WIDTH{1'b0}}, wdata_q} << {off_q, 3'b000};
  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      b0_q    <= '0;
      b1_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_i) begin
          we_q    <= we_i;
          f3_q    <= funct3_i;
          addr_q  <= addr_i;
          wdata_q <= wdata_i;
          err_q   <= req_err;
          state_q <= req_err ? RESP : BEAT0;
        end
        BEAT0: begin
          if (!we_q) b0_q <= mem_data_i;
          state_q <= cross_q ? BEAT1 : RESP;
        end
        BEAT1: begin
          if (!we_q) b1_q <= mem_data_i;
          state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr_o = '0;
    mem_data_o = '0;
    mem_we_o   = 1'b0;
    mem_be_o   = '0;
    case (state_q)
      BEAT0: begin
        mem_addr_o = word_addr;
        mem_we_o   = we_q;
        mem_be_o   = we_q ? wide_be[3:0] : 4'b0000;
        mem_data_o = we_q ? wide_data[DATA_WIDTH-1:0] : '0;
      end
      BEAT1: begin
        mem_addr_o = word_addr + ADDR_WIDTH'(4);
        mem_we_o   = we_q;
        mem_be_o   = we_q ? wide_be[7:4] : 4'b0000;
        mem_data_o = we_q ? wide_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
      end
      default: ;
    endcase
  end

  lsu_load_extend u_ext (
    .bytes_i  ({b1_q, b0_q}),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (ext_data)
  );

  assign ready_o      = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign err_o        = resp_valid_o && err_q;
  assign rdata_o      = (resp_valid_o && !we_q && !err_q) ? ext_data : '0;

endmodule

// File: tb/tb_lsu_tcm_master.sv
// Directed self-checking bench for lsu_tcm_master with a byte-array TCM model.
module tb_lsu_tcm_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic        ready, resp, err, mwe;
  logic [31:0] rdata, maddr, mdata, mrdata;
  logic [3:0]  mbe;

  logic        na_req, na_we;
  logic [2:0]  na_f3;
  logic [31:0] na_addr, na_wdata;
  logic        na_ready, na_resp, na_err, na_mwe;
  logic [31:0] na_rdata, na_maddr, na_mdata;
  logic [31:0] na_mrdata = 32'h0;
  logic [3:0]  na_mbe;

  logic [7:0]  mem [256];
  logic        poke;
  logic [7:0]  poke_a, poke_d;
  logic [7:0]  ma;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_tcm_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst_ni(rst_n), .req_i(req), .ready_o(ready), .we_i(we), .funct3_i(f3),
    .addr_i(addr), .wdata_i(wdata), .resp_valid_o(resp), .rdata_o(rdata), .err_o(err),
    .mem_addr_o(maddr), .mem_data_o(mdata), .mem_we_o(mwe), .mem_be_o(mbe),
    .mem_data_i(mrdata)
  );

  lsu_tcm_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) u_dut_na (
    .clk(clk), .rst_ni(rst_n), .req_i(na_req), .ready_o(na_ready), .we_i(na_we),
    .funct3_i(na_f3), .addr_i(na_addr), .wdata_i(na_wdata), .resp_valid_o(na_resp),
    .rdata_o(na_rdata), .err_o(na_err), .mem_addr_o(na_maddr), .mem_data_o(na_mdata),
    .mem_we_o(na_mwe), .mem_be_o(na_mbe), .mem_data_i(na_mrdata)
  );

  always @(posedge clk) begin
    if (mwe)
      for (int i = 0; i < 4; i++)
        if (mbe[i]) mem[maddr[7:0] + 8'(i)] <= mdata[8*i +: 8];
    if (poke) mem[poke_a] <= poke_d;
  end

  always_comb begin
    ma     = maddr[7:0];
    mrdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
  end

  task automatic poke_byte(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    poke = 1'b1; poke_a = a; poke_d = d;
    @(posedge clk);
    #1 poke = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic issue_na(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    na_req = 1'b1; na_we = w; na_f3 = f; na_addr = a; na_wdata = d;
    @(posedge clk);
    #1 na_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [127:0] g, e;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    g = {ready, resp, err, rdata, mwe, mbe, maddr, mdata};
    e = {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0};
    checks++; if (g !== e) begin errors++; $display("FAIL reset_outputs: got %h exp %h", g, e); end
    rst_n = 1'b1;
  endtask

  task automatic test_store_aligned();
    logic [127:0] g, e;
    issue(1'b1, 3'b010, 32'h10, 32'hA0B0C0D0);
    @(negedge clk);
    g = {mwe, mbe, maddr, mdata, resp}; e = {1'b1, 4'hF, 32'h10, 32'hA0B0C0D0, 1'b0};
    checks++; if (g !== e) begin errors++; $display("FAIL sw_beat0: got %h exp %h", g, e); end
    @(negedge clk);
    g = {resp, err, rdata, mwe, ready}; e = {1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    checks++; if (g !== e) begin errors++; $display("FAIL sw_resp: got %h exp %h", g, e); end
  endtask

  task automatic test_byte();
    logic [127:0] g, e;
    issue(1'b1, 3'b000, 32'h13, 32'h000000EE);
    @(negedge clk);
    g = {mwe, mbe, maddr, mdata}; e = {1'b1, 4'b1000, 32'h10, 32'hEE000000};
    checks++; if (g !== e) begin errors++; $display("FAIL sb_beat0: got %h exp %h", g, e); end
    @(negedge clk);
    issue(1'b0, 3'b000, 32'h13, 32'h0);
    @(negedge clk);
    g = {mwe, mbe, maddr, resp}; e = {1'b0, 4'h0, 32'h10, 1'b0};
    checks++; if (g !== e) begin errors++; $display("FAIL lb_beat0: got %h exp %h", g, e); end
    @(negedge clk);
    g = {resp, err, rdata}; e = {1'b1, 1'b0, 32'hFFFFFFEE};
    checks++; if (g !== e) begin errors++; $display("FAIL lb_rdata: got %h exp %h", g, e); end
    issue(1'b0, 3'b100, 32'h13, 32'h0);
    repeat (2) @(negedge clk);
    g = {resp, err, rdata}; e = {1'b1, 1'b0, 32'h000000EE};
    checks++; if (g !== e) begin errors++; $display("FAIL lbu_rdata: got %h exp %h", g, e); end
  endtask

  task automatic test_split_store();
    logic [127:0] g, e;
    poke_byte(8'h20, 8'h5A);
    poke_byte(8'h25, 8'h77);
    issue(1'b1, 3'b010, 32'h21, 32'h11223344);
    @(negedge clk);
    g = {mwe, mbe, maddr, mdata, resp}; e = {1'b1, 4'b1110, 32'h20, 32'h22334400, 1'b0};
    checks++; if (g !== e) begin errors++; $display("FAIL split_sw_beat0: got %h exp %h", g, e); end
    @(negedge clk);
    g = {mwe, mbe, maddr, mdata, resp}; e = {1'b1, 4'b0001, 32'h24, 32'h00000011, 1'b0};
    checks++; if (g !== e) begin errors++; $display("FAIL split_sw_beat1: got %h exp %h", g, e); end
    @(negedge clk);
    g = {resp, err, rdata, mwe}; e = {1'b1, 1'b0, 32'h0, 1'b0};
    checks++; if (g !== e) begin errors++; $display("FAIL split_sw_resp: got %h exp %h", g, e); end
    issue(1'b0, 3'b010, 32'h21, 32'h0);
    repeat (3) @(negedge clk);
    g = {resp, rdata}; e = {1'b1, 32'h11223344};
    checks++; if (g !== e) begin errors++; $display("FAIL split_lw_readback: got %h exp %h", g, e); end
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    repeat (2) @(negedge clk);
    g = {resp, rdata}; e = {1'b1, 32'h2233445A};
    checks++; if (g !== e) begin errors++; $display("FAIL split_lane0_kept: got %h exp %h", g, e); end
    issue(1'b0, 3'b100, 32'h25, 32'h0);
    repeat (2) @(negedge clk);
    g = {resp, rdata}; e = {1'b1, 32'h00000077};
    checks++; if (g !== e) begin errors++; $display("FAIL split_lane5_kept: got %h exp %h", g, e); end
  endtask

  task automatic test_split_load();
    logic [127:0] g, e;
    poke_byte(8'h23, 8'h80);
    poke_byte(8'h24, 8'h7F);
    issue(1'b0, 3'b001, 32'h23, 32'h0);
    @(negedge clk);
    g = {mwe, mbe, maddr}; e = {1'b0, 4'h0, 32'h20};
    checks++; if (g !== e) begin errors++; $display("FAIL lh_split_beat0: got %h exp %h", g, e); end
    @(negedge clk);
    g = {mwe, maddr, resp}; e = {1'b0, 32'h24, 1'b0};
    checks++; if (g !== e) begin errors++; $display("FAIL lh_split_beat1: got %h exp %h", g, e); end
    @(negedge clk);
    g = {resp, err, rdata}; e = {1'b1, 1'b0, 32'h00007F80};
    checks++; if (g !== e) begin errors++; $display("FAIL lh_split_rdata: got %h exp %h", g, e); end
    issue(1'b0, 3'b101, 32'h23, 32'h0);
    repeat (3) @(negedge clk);
    g = {resp, rdata}; e = {1'b1, 32'h00007F80};
    checks++; if (g !== e) begin errors++; $display("FAIL lhu_split_rdata: got %h exp %h", g, e); end
  endtask

  task automatic test_illegal();
    logic [127:0] g, e;
    issue(1'b1, 3'b011, 32'h40, 32'hFFFFFFFF);
    @(negedge clk);
    g = {resp, err, rdata, mwe, mbe}; e = {1'b1, 1'b1, 32'h0, 1'b0, 4'h0};
    checks++; if (g !== e) begin errors++; $display("FAIL illegal_resp: got %h exp %h", g, e); end
    @(negedge clk);
    g = {ready, resp, err}; e = {1'b1, 1'b0, 1'b0};
    checks++; if (g !== e) begin errors++; $display("FAIL illegal_idle: got %h exp %h", g, e); end
  endtask

  task automatic test_wrap();
    logic [127:0] g, e;
    poke_byte(8'hFD, 8'h01);
    poke_byte(8'hFE, 8'h02);
    poke_byte(8'hFF, 8'h03);
    poke_byte(8'h00, 8'h04);
    issue(1'b0, 3'b010, 32'hFFFFFFFD, 32'h0);
    @(negedge clk);
    g = maddr; e = 32'hFFFFFFFC;
    checks++; if (g !== e) begin errors++; $display("FAIL wrap_beat0_addr: got %h exp %h", g, e); end
    @(negedge clk);
    g = maddr; e = 32'h0;
    checks++; if (g !== e) begin errors++; $display("FAIL wrap_beat1_addr: got %h exp %h", g, e); end
    @(negedge clk);
    g = {resp, err, rdata}; e = {1'b1, 1'b0, 32'h04030201};
    checks++; if (g !== e) begin errors++; $display("FAIL wrap_rdata: got %h exp %h", g, e); end
  endtask

  task automatic test_half_misaligned();
    logic [127:0] g, e;
    poke_byte(8'h31, 8'h34);
    poke_byte(8'h32, 8'hF2);
    issue(1'b0, 3'b001, 32'h31, 32'h0);
    @(negedge clk);
    g = {maddr, resp}; e = {32'h30, 1'b0};
    checks++; if (g !== e) begin errors++; $display("FAIL lh1_beat0: got %h exp %h", g, e); end
    @(negedge clk);
    g = {resp, err, rdata}; e = {1'b1, 1'b0, 32'hFFFFF234};
    checks++; if (g !== e) begin errors++; $display("FAIL lh1_rdata: got %h exp %h", g, e); end
    issue(1'b1, 3'b001, 32'h31, 32'hFFFFABCD);
    @(negedge clk);
    g = {mwe, mbe, maddr, mdata}; e = {1'b1, 4'b0110, 32'h30, 32'hFFABCD00};
    checks++; if (g !== e) begin errors++; $display("FAIL sh1_beat0: got %h exp %h", g, e); end
    @(negedge clk);
    g = {resp, err}; e = {1'b1, 1'b0};
    checks++; if (g !== e) begin errors++; $display("FAIL sh1_resp: got %h exp %h", g, e); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] g, e;
    int seen;
    issue(1'b1, 3'b010, 32'h22, 32'hDEADBEEF);
    @(negedge clk);
    g = {mwe, mbe}; e = {1'b1, 4'b1100};
    checks++; if (g !== e) begin errors++; $display("FAIL rstmid_beat0: got %h exp %h", g, e); end
    @(negedge clk);
    g = {mwe, mbe, maddr}; e = {1'b1, 4'b0011, 32'h24};
    checks++; if (g !== e) begin errors++; $display("FAIL rstmid_beat1: got %h exp %h", g, e); end
    rst_n = 1'b0;
    #1;
    g = {mwe, mbe, resp}; e = {1'b0, 4'h0, 1'b0};
    checks++; if (g !== e) begin errors++; $display("FAIL rstmid_drop: got %h exp %h", g, e); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp !== 1'b0) seen++;
    end
    g = {ready, 32'(seen)}; e = {1'b1, 32'd0};
    checks++; if (g !== e) begin errors++; $display("FAIL rstmid_no_resp: got %h exp %h", g, e); end
  endtask

  task automatic test_no_misalign();
    logic [127:0] g, e;
    issue_na(1'b0, 3'b010, 32'h02, 32'h0);
    @(negedge clk);
    g = {na_resp, na_err, na_mwe, na_mbe, na_rdata}; e = {1'b1, 1'b1, 1'b0, 4'h0, 32'h0};
    checks++; if (g !== e) begin errors++; $display("FAIL na_lw2_err: got %h exp %h", g, e); end
    issue_na(1'b1, 3'b001, 32'h01, 32'h0000BEEF);
    @(negedge clk);
    g = {na_resp, na_mwe, na_mbe, na_maddr, na_mdata}; e = {1'b0, 1'b1, 4'b0110, 32'h0, 32'h00BEEF00};
    checks++; if (g !== e) begin errors++; $display("FAIL na_sh1_beat0: got %h exp %h", g, e); end
    @(negedge clk);
    g = {na_resp, na_err}; e = {1'b1, 1'b0};
    checks++; if (g !== e) begin errors++; $display("FAIL na_sh1_resp: got %h exp %h", g, e); end
  endtask

  initial begin
    req = 1'b0; we = 1'b0; f3 = '0; addr = '0; wdata = '0;
    na_req = 1'b0; na_we = 1'b0; na_f3 = '0; na_addr = '0; na_wdata = '0;
    poke = 1'b0; poke_a = '0; poke_d = '0;
    test_reset();
    test_store_aligned();
    test_byte();
    test_split_store();
    test_split_load();
    test_illegal();
    test_wrap();
    test_half_misaligned();
    test_reset_mid();
    test_no_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
